bitlogic_pipe: RTL and testbench

//  Parametrised, pipelined successor to the fixed 16-bit combinational bitwise gates.
//  - Applies one of four bitwise ops to two WIDTH-bit operands.
//  - 2-stage pipeline: S1 operand register, S2 result register.
//  - valid/ready handshake on both sides; full throughput.
//  - Emits Hack-ALU style zr/ng flags with each result.
//  - Feeds the ALU/datapath in place of the standalone and16/or16/not16 instances.

---
 rtl/bitlogic_pipe.sv | 128 ++++++++++++
 tb/tb_bitlogic_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitlogic_pipe.sv
// bitlogic_pipe: two-stage pipelined bitwise unit (AND/OR/XOR/NOT a) with
// valid/ready handshakes on both sides and Hack-ALU style zr/ng flags.
//
// Optional feature: define BITLOGIC_ACC_EN to add a sticky-OR accumulator of
// every retired result (ports acc_clr, acc_q).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready is combinational
//   a, b, op          operands and opcode (00 AND, 01 OR, 10 XOR, 11 NOT a)
//   out_valid/out_ready output handshake
//   y, zr, ng         registered result and flags
//   acc_clr, acc_q    (BITLOGIC_ACC_EN only) sync clear / accumulated OR
module bitlogic_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zr,
    output logic             ng
`ifdef BITLOGIC_ACC_EN
    ,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] acc_q
`endif
);

    localparam int unsigned OP_W = 2;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [OP_W-1:0]  r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zr;
    logic             r_ng;

    logic             w_s2_adv;
    logic             w_s1_load;
    logic             w_in_ready;
    logic [WIDTH-1:0] w_result;

    // Handshake: S2 frees when empty or being popped; S1 frees when empty or advancing.
    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_s1_load  = in_valid & w_in_ready;

    // Bitwise function evaluated on the S1 operands.
    always_comb begin
        w_result = '0;
        unique case (r_s1_op)
            2'b00:   w_result = r_s1_a & r_s1_b;
            2'b01:   w_result = r_s1_a | r_s1_b;
            2'b10:   w_result = r_s1_a ^ r_s1_b;
            default: w_result = ~r_s1_a;
        endcase
    end

    // Stage 1: operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else begin
            r_s1_valid <= w_s1_load | (r_s1_valid & ~w_s2_adv);
            if (w_s1_load) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    // Stage 2: result register with flags derived from the same value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_zr       <= 1'b0;
            r_ng       <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_adv | (r_s2_valid & ~out_ready);
            if (w_s2_adv) begin
                r_y  <= w_result;
                r_zr <= ~|w_result;
                r_ng <= w_result[WIDTH-1];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign zr        = r_zr;
    assign ng        = r_ng;

`ifdef BITLOGIC_ACC_EN
    logic [WIDTH-1:0] r_acc;
    logic             w_retire;

    assign w_retire = r_s2_valid & out_ready;

    // Sticky OR of retired results; clear wins over a same-cycle retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_retire) begin
            r_acc <= r_acc | r_y;
        end
    end

    assign acc_q = r_acc;
`endif

endmodule

// File: tb/tb_bitlogic_pipe.sv
// Testbench for bitlogic_pipe: randomized and directed stimulus, scoreboard
// of expected results from a per-bit truth-table model, decoupled monitor.
`timescale 1ns/1ps
module tb_bitlogic_pipe;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] y;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         zr;
    logic         ng;
`ifdef BITLOGIC_ACC_EN
    logic         acc_clr = 1'b0;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_m = '0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;
    bit   rand_ready = 1'b0;
    logic fixed_ready = 1'b1;
    exp_t sb[$];

    // Truth tables indexed by {a_bit, b_bit}: AND, OR, XOR, NOT a.
    logic [3:0] tt [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};

    bitlogic_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zr        (zr),
        .ng        (ng)
`ifdef BITLOGIC_ACC_EN
        ,
        .acc_clr   (acc_clr),
        .acc_q     (acc_q)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic [1:0] o);
        logic [W-1:0] r;
        logic [3:0]   t;
        t = tt[o];
        for (int i = 0; i < int'(W); i++) r[i] = t[{x[i], z[i]}];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor: pops and compares on every retire, pushes on every accept.
    task automatic monitor();
        exp_t         e;
        logic         ret;
        logic [W-1:0] ry;
        forever begin
            @(negedge clk);
            cyc++;
            ret = 1'b0;
            ry  = '0;
            if (!rst_n) begin
`ifdef BITLOGIC_ACC_EN
                acc_m = '0;
`endif
                continue;
            end
`ifdef BITLOGIC_ACC_EN
            chk("acc_q", acc_q, acc_m);
`endif
            if (out_valid && out_ready) begin
                ret = 1'b1;
                if (sb.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    e  = sb.pop_front();
                    ry = e.y;
                    chk("y", y, e.y);
                    chk("zr", W'(zr), W'(e.y == '0));
                    chk("ng", W'(ng), W'(e.y[W-1]));
                    if (chk_lat) chk("latency", W'(cyc - e.cyc), W'(2));
                end
            end
            if (in_valid && in_ready) sb.push_back('{ref_y(a, b, op), cyc});
`ifdef BITLOGIC_ACC_EN
            if (acc_clr) acc_m = '0;
            else if (ret) acc_m = acc_m | ry;
`endif
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [1:0] top);
        a = ta; b = tb2; op = top; in_valid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i > 200) begin fail("send_timeout"); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
            if (i > 500) begin fail("drain_timeout"); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic stimulus();
        logic [W-1:0] frozen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_y", y, W'(0));
        chk("rst_zr", W'(zr), W'(0));
        chk("rst_ng", W'(ng), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // OR back-to-back with latency checks
        fixed_ready = 1'b1;
        chk_lat = 1'b1;
        send(W'(16'h0000), W'(16'hFFFF), 2'b01);
        send(W'(16'hAAAA), W'(16'h5555), 2'b01);
        send(W'(16'h0000), W'(16'h0000), 2'b01);
        send(W'(16'hFFFF), W'(16'hFFFF), 2'b01);
        // Other ops
        send(W'(16'hF0F0), W'(16'hFF00), 2'b00);
        send(W'(16'h1234), W'(16'h1234), 2'b10);
        send(W'(16'h00FF), W'(16'hFFFF), 2'b11);
        drain();
        chk_lat = 1'b0;

        // Backpressure: pipe fills with two ops, third is held off
        fixed_ready = 1'b0;
        send(W'(16'h0F0F), W'(16'h3000), 2'b01);
        send(W'(16'h1111), W'(16'h2222), 2'b10);
        a = W'(16'h8001); b = W'(16'h0000); op = 2'b11; in_valid = 1'b1;
        frozen = ref_y(W'(16'h0F0F), W'(16'h3000), 2'b01);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_out_valid", W'(out_valid), W'(1));
            chk("stall_y", y, frozen);
        end
        @(posedge clk); #1;
        fixed_ready = 1'b1;
        send(W'(16'h8001), W'(16'h0000), 2'b11);
        drain();

        // Async reset with two ops in flight
        fixed_ready = 1'b0;
        send(W'(16'h00F0), W'(16'h0000), 2'b01);
        send(W'(16'h0F00), W'(16'h0000), 2'b01);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_y", y, W'(0));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fixed_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_out_valid", W'(out_valid), W'(0));
            chk("post_rst_in_ready", W'(in_ready), W'(1));
        end
        @(posedge clk); #1;

`ifdef BITLOGIC_ACC_EN
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        send(W'(16'h000F), W'(16'h0000), 2'b01);
        send(W'(16'h0F00), W'(16'h0000), 2'b01);
        drain();
        @(negedge clk);
        chk("acc_0f0f", acc_q, W'(16'h0F0F));
        @(posedge clk); #1;
        fixed_ready = 1'b0;
        send(W'(16'hF000), W'(16'h0000), 2'b01);
        for (int i = 0; ; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (i > 50) begin fail("acc_wait_timeout"); break; end
        end
        @(posedge clk); #1;
        fixed_ready = 1'b1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        @(negedge clk);
        chk("acc_clr_priority", acc_q, W'(0));
        @(posedge clk); #1;
        drain();
`endif

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drain();
        chk("final_queue_empty", W'(sb.size()), W'(0));
    endtask

    initial begin
        fork
            monitor();
            ready_drv();
            stimulus();
            begin
                #500000;
                fail("global_timeout");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
